// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 transmit path: FSM state encoding and line levels.
package rs232_pkg;

  // State encoding shared by the transmitter FSM.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  // Level of an idle (mark) serial line; also the stop-bit level.
  localparam logic RS232_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    StIdle  = IDLE,
    StStart = START,
    StData  = DATA,
    StPar   = PAR,
    StStop  = STOP
  } tx_state_e;

endpackage

// File: rtl/rs232_tx.sv
// RS232 serial transmitter. Accepts one word per valid/ready handshake and sends it LSB-first
// as start bit, DATA_BITS data bits, optional parity bit and STOP_BITS stop bits, one bit per
// baud_en pulse. Parity is compiled in only when RS232_TX_PARITY_EN is defined; PARITY_ODD
// exists only in that build.
module rs232_tx
  import rs232_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1
`ifdef RS232_TX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic                 txd
);

  localparam int unsigned CntW = $clog2(DATA_BITS + 1);

  tx_state_e            state;
  logic [DATA_BITS-1:0] shifter;
  logic [CntW-1:0]      bit_cnt;
  logic [CntW-1:0]      stop_cnt;
`ifdef RS232_TX_PARITY_EN
  logic                 parity;
`endif

  // Frame FSM; every output is registered and txd only moves on baud_en edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      shifter  <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      txd      <= RS232_IDLE_LEVEL;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
`ifdef RS232_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        StIdle: begin
          // A baud_en coinciding with accept is deliberately ignored: the start bit
          // waits for the next full baud period.
          if (tx_valid && tx_ready) begin
            shifter  <= tx_data;
            tx_ready <= 1'b0;
            state    <= StStart;
`ifdef RS232_TX_PARITY_EN
            parity   <= (^tx_data) ^ PARITY_ODD;
`endif
          end
        end
        StStart: begin
          if (baud_en) begin
            txd     <= 1'b0;
            bit_cnt <= '0;
            state   <= StData;
          end
        end
        StData: begin
          if (baud_en) begin
            if (bit_cnt == CntW'(DATA_BITS)) begin
              // Last data bit has had its full period: begin the next field now.
`ifdef RS232_TX_PARITY_EN
              txd      <= parity;
              state    <= StPar;
`else
              txd      <= RS232_IDLE_LEVEL;
              stop_cnt <= CntW'(1);
              state    <= StStop;
`endif
            end else begin
              txd     <= shifter[0];
              shifter <= {1'b0, shifter[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + CntW'(1);
            end
          end
        end
`ifdef RS232_TX_PARITY_EN
        StPar: begin
          if (baud_en) begin
            txd      <= RS232_IDLE_LEVEL;
            stop_cnt <= CntW'(1);
            state    <= StStop;
          end
        end
`endif
        StStop: begin
          if (baud_en) begin
            if (stop_cnt == CntW'(STOP_BITS)) begin
              state    <= StIdle;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
            end else begin
              txd      <= RS232_IDLE_LEVEL;
              stop_cnt <= stop_cnt + CntW'(1);
            end
          end
        end
        default: begin
          state    <= StIdle;
          txd      <= RS232_IDLE_LEVEL;
          tx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_tx.sv
// Self-checking bench for rs232_tx: two instances (8N1 and 7-bit/2-stop) checked every cycle
// against a frame-list model, plus directed literal checks of bit patterns and timing.
module tb_rs232_tx;

`ifdef RS232_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] bcnt  = 2'd0;
  logic       baud_en;
  int         cyc   = 0;

  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic [7:0] data_a  = 8'h00;
  logic [6:0] data_b  = 7'h00;
  logic       ready_a, done_a, txd_a;
  logic       ready_b, done_b, txd_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Baud enable every 4 clocks; the value seen at a negedge is the one the next posedge uses.
  always @(posedge clk) bcnt <= bcnt + 2'd1;
  assign baud_en = (bcnt == 2'd3);
  always @(posedge clk) cyc <= cyc + 1;

`ifdef RS232_TX_PARITY_EN
  rs232_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut_a (
`else
  rs232_tx #(.DATA_BITS(8), .STOP_BITS(1)) dut_a (
`endif
    .clk(clk), .rst_n(rst_n), .baud_en(baud_en), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx_done(done_a), .txd(txd_a)
  );

`ifdef RS232_TX_PARITY_EN
  rs232_tx #(.DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1'b1)) dut_b (
`else
  rs232_tx #(.DATA_BITS(7), .STOP_BITS(2)) dut_b (
`endif
    .clk(clk), .rst_n(rst_n), .baud_en(baud_en), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .tx_done(done_b), .txd(txd_b)
  );

  // Model: on accept, build the whole frame as a bit list; each later baud_en emits the next
  // bit, and the baud_en after the list is exhausted completes the frame.
  typedef struct packed {
    logic        ready;
    logic        done;
    logic        txd;
    logic        busy;
    logic [4:0]  pos;
    logic [4:0]  len;
    logic [15:0] bits;
    int unsigned acc;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_reset();
    model_t n = '0;
    n.ready = 1'b1;
    n.txd   = 1'b1;
    return n;
  endfunction

  function automatic model_t model_step(model_t m, logic valid, logic [7:0] data, int dbits,
                                        int sbits, logic odd, logic baud);
    model_t n = m;
    logic   par = odd;
    n.done = 1'b0;
    if (m.ready && valid) begin
      n.ready = 1'b0;
      n.busy  = 1'b1;
      n.pos   = '0;
      n.acc   = m.acc + 1;
      n.bits  = '1;
      n.bits[0] = 1'b0;
      for (int i = 0; i < dbits; i++) begin
        n.bits[1+i] = data[i];
        par = par ^ data[i];
      end
      if (P == 1) n.bits[1+dbits] = par;
      n.len = 5'(1 + dbits + P + sbits);
    end else if (m.busy && baud) begin
      if (m.pos < m.len) begin
        n.txd = m.bits[m.pos];
        n.pos = m.pos + 5'd1;
      end else begin
        n.busy  = 1'b0;
        n.done  = 1'b1;
        n.ready = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= model_reset();
      mb <= model_reset();
    end else begin
      ma <= model_step(ma, valid_a, data_a, 8, 1, 1'b0, baud_en);
      mb <= model_step(mb, valid_b, {1'b0, data_b}, 7, 2, 1'b1, baud_en);
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("a_txd", txd_a, ma.txd);
    check("a_ready", ready_a, ma.ready);
    check("a_done", done_a, ma.done);
    check("b_txd", txd_b, mb.txd);
    check("b_ready", ready_b, mb.ready);
    check("b_done", done_b, mb.done);
  end

  function automatic logic txd_of(input bit inst);
    return inst ? txd_b : txd_a;
  endfunction

  function automatic logic done_of(input bit inst);
    return inst ? done_b : done_a;
  endfunction

  task automatic send(input bit inst, input logic [7:0] d, input bit hold);
    int unsigned a0 = inst ? mb.acc : ma.acc;
    int k = 0;
    @(negedge clk);
    if (inst) begin
      data_b  = d[6:0];
      valid_b = 1'b1;
    end else begin
      data_a  = d;
      valid_a = 1'b1;
    end
    while (k < 400 && (inst ? mb.acc : ma.acc) == a0) begin
      @(negedge clk);
      k++;
    end
    check_int("accept_seen", int'(k < 400), 1);
    if (!hold) begin
      if (inst) valid_b = 1'b0;
      else valid_a = 1'b0;
    end
  endtask

  // Waits for the start bit, then samples n bits, one per baud period (v[0] is the start bit).
  task automatic capture(input bit inst, input int n, output logic [15:0] v, output int t0);
    int k = 0;
    v  = '0;
    t0 = 0;
    while (k < 400) begin
      @(negedge clk);
      if (txd_of(inst) == 1'b0) break;
      k++;
    end
    check_int("start_seen", int'(k < 400), 1);
    t0   = cyc;
    v[0] = txd_of(inst);
    for (int i = 1; i < n; i++) begin
      repeat (4) @(negedge clk);
      v[i] = txd_of(inst);
    end
  endtask

  task automatic wait_done(input bit inst, output int t);
    int k = 0;
    t = 0;
    while (k < 400) begin
      @(negedge clk);
      if (done_of(inst) == 1'b1) break;
      k++;
    end
    check_int("done_seen", int'(k < 400), 1);
    t = cyc;
  endtask

  initial begin
    logic [15:0] v;
    int          t0, t1, d1, c, k;
    logic        s1, s2;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_txd", txd_a, 1'b1);
    check("rst_ready", ready_a, 1'b1);
    check("rst_done", done_a, 1'b0);
    check("rst_b_txd", txd_b, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: 0x55 8N1, start + data pattern and 40-clk start-to-done
    send(1'b0, 8'h55, 1'b0);
    capture(1'b0, 9, v, t0);
    check_int("t1_bits", int'(v[8:0]), 'h0AA);
    wait_done(1'b0, t1);
    check_int("t1_done_time", t1 - t0, 40 + 4 * P);
    repeat (6) @(negedge clk);

`ifdef RS232_TX_PARITY_EN
    // 2: parity of 0x07 -> even 1, odd 0
    send(1'b0, 8'h07, 1'b0);
    capture(1'b0, 10, v, t0);
    check_int("t2_even_par", int'(v[9]), 1);
    wait_done(1'b0, t1);
    send(1'b1, 8'h07, 1'b0);
    capture(1'b1, 9, v, t0);
    check_int("t2_odd_par", int'(v[8]), 0);
    wait_done(1'b1, t1);
    repeat (6) @(negedge clk);
`endif

    // 3: valid held high, back-to-back frames, data changes while busy ignored
    send(1'b0, 8'hA5, 1'b1);
    data_a = 8'h3C;
    capture(1'b0, 9, v, t0);
    check_int("t3_frame1", int'(v[8:0]), 'h14A);
    wait_done(1'b0, d1);
    capture(1'b0, 9, v, t0);
    valid_a = 1'b0;
    data_a  = 8'h00;
    check_int("t3_frame2", int'(v[8:0]), 'h078);
    check_int("t3_gap", t0 - d1, 4);
    wait_done(1'b0, t1);
    repeat (6) @(negedge clk);

    // 4: accept coincident with baud_en does not start the frame
    k = 0;
    @(negedge clk);
    while (baud_en != 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    c = cyc;
    data_a  = 8'hC3;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    check("t4_busy", ready_a, 1'b0);
    capture(1'b0, 9, v, t0);
    check_int("t4_latency", t0 - c, 5);
    check_int("t4_bits", int'(v[8:0]), 'h186);
    wait_done(1'b0, t1);
    repeat (6) @(negedge clk);

    // 5: reset during bit 3 of 0xFF, then a clean frame
    send(1'b0, 8'hFF, 1'b0);
    capture(1'b0, 1, v, t0);
    repeat (17) @(negedge clk);
    check("t5_busy_before", ready_a, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_txd", txd_a, 1'b1);
    check("t5_rst_ready", ready_a, 1'b1);
    check("t5_rst_done", done_a, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    send(1'b0, 8'h5A, 1'b0);
    capture(1'b0, 9, v, t0);
    check_int("t5_bits", int'(v[8:0]), 'h0B4);
    wait_done(1'b0, t1);
    check_int("t5_done_time", t1 - t0, 40 + 4 * P);
    repeat (6) @(negedge clk);

    // 6: 7 data bits, 2 stop bits, 0x41
    send(1'b1, 8'h41, 1'b0);
    capture(1'b1, 8, v, t0);
    check_int("t6_bits", int'(v[7:0]), 'h82);
    repeat (4 * (1 + P)) @(negedge clk);
    s1 = txd_b;
    repeat (4) @(negedge clk);
    s2 = txd_b;
    check("t6_stop1", s1, 1'b1);
    check("t6_stop2", s2, 1'b1);
    wait_done(1'b1, t1);
    check_int("t6_done_time", t1 - t0, 40 + 4 * P);
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
